// File: rtl/noc_pkg.sv
// Shared flit layout and widths for the mesh network endpoint.
package noc_pkg;

  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned COORD_W = 4;

  typedef struct packed {
    logic [7:0]         payload;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } flit_t;

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous RX flit FIFO; a write while full is taken only alongside a read.
module noc_rx_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_wr;
  logic              do_rd;

  // Extra MSB on each pointer separates full from empty when the low bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr[AW-1:0]] <= wr_data;
        wptr              <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_endpoint.sv
// Tile network interface: credit-controlled TX of single-flit packets and
// buffered RX with credit return to the router's L port.
module noc_endpoint
  import noc_pkg::*;
#(
  parameter int unsigned XCOORD   = 0,
  parameter int unsigned YCOORD   = 0,
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        tx_payload_i,
  input  logic [3:0]        tx_dest_x_i,
  input  logic [3:0]        tx_dest_y_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [FLIT_W-1:0] net_data_o,
  output logic              net_enable_o,
  input  logic              net_credit_i,
  input  logic [FLIT_W-1:0] net_data_i,
  input  logic              net_valid_i,
  output logic              net_credit_o,
  output logic [FLIT_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [7:0]        misroute_cnt_o,
  output logic              credit_err_o,
  output logic              rx_overflow_o
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned PW = $clog2(RX_DEPTH + 2);

  logic [CW-1:0] credit_cnt;
  logic [PW-1:0] pending;
  logic          send;
  flit_t         tx_flit;
  flit_t         rx_flit;
  logic          dest_match;
  logic          rx_write;
  logic          misroute;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign tx_ready_o = (credit_cnt != '0);
  assign send       = tx_valid_i && tx_ready_o;
  assign tx_flit    = '{payload: tx_payload_i, dest_x: tx_dest_x_i, dest_y: tx_dest_y_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt   <= CW'(CREDITS);
      credit_err_o <= 1'b0;
      net_enable_o <= 1'b0;
      net_data_o   <= '0;
    end else begin
      unique case ({send, net_credit_i})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: begin
          if (credit_cnt == CW'(CREDITS)) credit_err_o <= 1'b1;
          else                            credit_cnt   <= credit_cnt + 1'b1;
        end
        default: ;
      endcase
      net_enable_o <= send;
      if (send) net_data_o <= tx_flit;
    end
  end

  assign rx_flit    = flit_t'(net_data_i);
  assign dest_match = (rx_flit.dest_x == COORD_W'(XCOORD)) && (rx_flit.dest_y == COORD_W'(YCOORD));
  assign rx_write   = net_valid_i && dest_match;
  assign misroute   = net_valid_i && !dest_match;
  assign rx_valid_o = !fifo_empty;
  assign pop        = rx_valid_o && rx_ready_i;

  noc_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_write),
    .wr_data (net_data_i),
    .rd_en   (pop),
    .rd_data (rx_data_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pop and misroute drop can both owe a credit in one cycle; only one returns per cycle.
  assign net_credit_o = (pending != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      misroute_cnt_o <= '0;
      rx_overflow_o  <= 1'b0;
    end else begin
      pending <= pending + PW'(pop) + PW'(misroute) - PW'(net_credit_o);
      if (misroute && misroute_cnt_o != 8'hFF) misroute_cnt_o <= misroute_cnt_o + 8'd1;
      if (rx_write && fifo_full && !pop) rx_overflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/noc_endpoint.md
# noc_endpoint

Local network interface attached to a router's L port, the opposite end of the router's credit-based link. It packs core-side send requests into single-flit packets and transmits them under credit flow control, then buffers flits arriving from the router for the core. Each flit drained or dropped returns one credit to the router. Every mesh tile instantiates one of these between its core and its router.

## Interface
Parameters:
- XCOORD, 0, this tile's X coordinate (4 bits)
- YCOORD, 0, this tile's Y coordinate (4 bits)
- CREDITS, 4, depth of the router's L input FIFO; initial TX credit count
- RX_DEPTH, 4, local RX FIFO depth (power of two, ≥2)

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tx_payload_i  in  8  payload byte to send
- tx_dest_x_i  in  4  destination X
- tx_dest_y_i  in  4  destination Y
- tx_valid_i  in  1  core send request
- tx_ready_o  out  1  endpoint can accept a send this cycle
- net_data_o  out  16  flit to router L input
- net_enable_o  out  1  flit valid strobe, one cycle per flit
- net_credit_i  in  1  router freed one L input slot
- net_data_i  in  16  flit from router L output
- net_valid_i  in  1  incoming flit strobe
- net_credit_o  out  1  one RX slot freed, one cycle per credit
- rx_data_o  out  16  head flit of RX FIFO
- rx_valid_o  out  1  RX FIFO non-empty
- rx_ready_i  in  1  core pops head flit
- misroute_cnt_o  out  8  saturating count of flits whose dest ≠ (XCOORD, YCOORD)
- credit_err_o  out  1  sticky: net_credit_i arrived while credit count = CREDITS
- rx_overflow_o  out  1  sticky: flit arrived with RX FIFO full and no pop

## Operation
- Flit format: [15:8] payload, [7:4] dest X, [3:0] dest Y.
- TX credit counter:
  - Width $clog2(CREDITS+1); resets to CREDITS.
  - tx_ready_o = (credit_cnt != 0). A send occurs when tx_valid_i && tx_ready_o; it decrements the counter.
  - net_credit_i increments the counter. A send and a credit in the same cycle leave it unchanged.
  - net_credit_i at CREDITS with no send: counter holds and credit_err_o sets.
- TX output register:
  - A send loads net_data_o with the flit and sets net_enable_o=1 for the next cycle only.
  - net_data_o holds its last value when idle.
- RX path:
  - A flit with net_valid_i and dest = (XCOORD, YCOORD) is written into the RX FIFO.
  - A flit with a mismatched dest is dropped: misroute_cnt_o increments (saturating at 255) and one credit is owed.
- RX FIFO:
  - rx_data_o/rx_valid_o show the head entry. A pop occurs when rx_valid_o && rx_ready_i; each pop owes one credit.
  - A write while full is accepted only if a pop happens in the same cycle; otherwise the flit is dropped, rx_overflow_o sets, and no credit is owed.
  - Pointers wrap modulo RX_DEPTH; a full/empty distinction bit is required.
- Credit return:
  - A pending counter (width $clog2(RX_DEPTH+2)) adds 0–2 owed credits per cycle (pop plus misroute drop).
  - While pending > 0, net_credit_o=1 for that cycle and pending decrements, so at most one credit is returned per cycle.
- Reset:
  - Registered outputs: net_enable_o=0, net_data_o=0, net_credit_o=0, misroute_cnt_o=0, credit_err_o=0, rx_overflow_o=0.
  - RX FIFO empty, so rx_valid_o=0; pending=0; credit_cnt=CREDITS, so tx_ready_o=1.
  - Reset mid-operation discards in-flight flits and pending credits.

## Timing
- Send accepted in cycle t: net_enable_o high in t+1.
- Credit received in t: tx_ready_o reflects it in t+1.
- Flit arriving in t with the FIFO empty: rx_valid_o=1 in t+1. There is no same-cycle bypass.
- Pop or drop in t: owed credit enters pending at the t clock edge; net_credit_o pulses in t+1 at the earliest.
- Back-to-back sends run at one per cycle while credits remain.

## Structure
- Package noc_pkg:
  - FLIT_W=16, COORD_W=4.
  - flit_t struct {payload[7:0], dest_x[3:0], dest_y[3:0]}.
- Sub-module noc_rx_fifo (parameter DEPTH): synchronous FIFO with wr_en, rd_en, full, empty and head data output. Write-while-full is permitted when rd_en is asserted in the same cycle.
- Credit counter, pending-credit counter, TX register and misroute logic live in noc_endpoint.

## Test plan
- TX credits: after reset, hold tx_valid_i for 6 cycles with CREDITS=4 and no net_credit_i → exactly 4 net_enable_o pulses; tx_ready_o=0 from the cycle after the 4th send. A single net_credit_i then → 5th flit sent.
- Flit packing: payload=0xA5, dest=(2,3) → net_data_o=0xA523 one cycle after acceptance.
- RX delivery: XCOORD=1, YCOORD=1, flit 0x3C11 in t → rx_data_o=0x3C11, rx_valid_o=1 in t+1. Pop in t+1 → net_credit_o=1 in t+2.
- Misroute with simultaneous pop: flit 0x0022 arrives in the same cycle as a pop → misroute_cnt_o=1, two consecutive net_credit_o pulses, FIFO count decrements by one.
- RX full: fill 4 flits with rx_ready_i=0, then send a 5th → rx_overflow_o=1, FIFO contents unchanged, no extra credit. Repeat with a pop in the same cycle → flit accepted, no overflow.
- Errors and reset: net_credit_i while credit_cnt=4 → credit_err_o=1. Assert rst mid-traffic → all outputs at their reset values next cycle and tx_ready_o=1.
